// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the regfile writeback block.
// Optional feature macro: REGFILE_WB_BYPASS_EN (see regfile_writeback.sv).
package regfile_wb_pkg;

    localparam int WB_DEPTH_DEFAULT  = 4;
    localparam int WB_ADDR_W_DEFAULT = 5;
    localparam int WB_DATA_W_DEFAULT = 32;
    localparam int WB_NUM_REGS       = 32;
    localparam int REG_ZERO          = 0;

    // One writeback request: destination register and the value to write.
    typedef struct packed {
        logic [WB_ADDR_W_DEFAULT-1:0] dst;
        logic [WB_DATA_W_DEFAULT-1:0] data;
    } wb_req_t;

    // One-hot bit for a register index inside the 32-entry pending bitmap.
    function automatic logic [WB_NUM_REGS-1:0] reg_bit(input logic [31:0] idx);
        logic [WB_NUM_REGS-1:0] res;
        res = '0;
        if (idx < 32'(WB_NUM_REGS)) begin
            res = WB_NUM_REGS'(1) << idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback request ports (W and Q) and the regfile-side outputs.
// Handshake: port W has no backpressure, a request is taken whenever w_valid is
// high. Port Q transfers when q_valid && q_ready are both high at a rising edge;
// q_ready never depends on q_valid in the same cycle.
interface regfile_writeback_if
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W_DEFAULT,
    parameter int DATA_W = WB_DATA_W_DEFAULT
);
    logic                   w_valid;
    logic [ADDR_W-1:0]      w_reg;
    logic [DATA_W-1:0]      w_data;
    logic                   q_valid;
    logic                   q_ready;
    logic [ADDR_W-1:0]      q_reg;
    logic [DATA_W-1:0]      q_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic [WB_NUM_REGS-1:0] pending_mask;
    logic                   err_waw;

    modport master (
        output w_valid, w_reg, w_data, q_valid, q_reg, q_data,
        input  q_ready, wr_en, wr_reg, wr_data, pending_mask, err_waw
    );

    modport slave (
        input  w_valid, w_reg, w_data, q_valid, q_reg, q_data,
        output q_ready, wr_en, wr_reg, wr_data, pending_mask, err_waw
    );
endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// Port-Q request FIFO. DEPTH must be a power of two so the pointers wrap
// naturally. Exposes per-slot valid/destination for the pending bitmap.
module wb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         i_push,
    input  logic [ADDR_W-1:0]            i_push_reg,
    input  logic [DATA_W-1:0]            i_push_data,
    input  logic                         i_pop,
    output logic [ADDR_W-1:0]            o_head_reg,
    output logic [DATA_W-1:0]            o_head_data,
    output logic                         o_full,
    output logic [CW-1:0]                o_count,
    output logic [DEPTH-1:0]             o_ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_reg
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;
    logic [PW-1:0] w_off;

    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && (r_count != '0);

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; cleared on reset so stale destinations never look live.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= '{dst: i_push_reg, data: i_push_data};
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_off       = '0;
        o_ent_valid = '0;
        o_ent_reg   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off          = PW'(i) - r_rd_ptr;
            o_ent_valid[i] = (CW'(w_off) < r_count);
            o_ent_reg[i]   = r_mem[i].dst;
        end
    end

    assign o_head_reg  = r_mem[r_rd_ptr].dst;
    assign o_head_data = r_mem[r_rd_ptr].data;
    assign o_count     = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// Regfile write-port owner: merges pipeline writeback (W, priority, no stall)
// with buffered long-latency results (Q) into one registered write per cycle,
// and publishes a bitmap of registers with writes still in flight.
// Optional feature macro: REGFILE_WB_BYPASS_EN adds two read-bypass ports that
// forward the output stage to same-cycle regfile readers.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH_DEFAULT,
    parameter int DATA_W = WB_DATA_W_DEFAULT,
    parameter int ADDR_W = WB_ADDR_W_DEFAULT
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    regfile_writeback_if.slave  bus
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]   byp_reg_a,
    input  logic [ADDR_W-1:0]   byp_reg_b,
    output logic                byp_hit_a,
    output logic                byp_hit_b,
    output logic [DATA_W-1:0]   byp_data_a,
    output logic [DATA_W-1:0]   byp_data_b
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);

    logic                         r_live;
    logic                         r_wr_en;
    logic [ADDR_W-1:0]            r_wr_reg;
    logic [DATA_W-1:0]            r_wr_data;
    logic                         r_err_waw;

    logic                         w_full;
    logic [CW-1:0]                w_count;
    logic [DEPTH-1:0]             w_ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_reg;
    logic [ADDR_W-1:0]            w_head_reg;
    logic [DATA_W-1:0]            w_head_data;

    logic                         w_q_ready;
    logic                         w_q_push;
    logic                         w_issue_w;
    logic                         w_pop;
    logic                         w_sel_en;
    logic [ADDR_W-1:0]            w_sel_reg;
    logic [DATA_W-1:0]            w_sel_data;
    logic [WB_NUM_REGS-1:0]       w_pending_mask;
    logic                         w_waw_hit;

    // Q is held off until the first edge after reset release, and whenever the
    // FIFO is full; a pop in the same cycle does not open a slot early.
    assign w_q_ready = r_live && !w_full;
    // Writes to r0 are accepted so the producer is not stalled, then dropped.
    assign w_q_push  = bus.q_valid && w_q_ready && (bus.q_reg != ZERO_REG);
    assign w_issue_w = bus.w_valid && (bus.w_reg != ZERO_REG);
    // FIFO pops use the registered count, so a same-cycle push waits one cycle.
    assign w_pop     = !w_issue_w && (w_count != '0);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CW     (CW)
    ) u_fifo (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .i_push      (w_q_push),
        .i_push_reg  (bus.q_reg),
        .i_push_data (bus.q_data),
        .i_pop       (w_pop),
        .o_head_reg  (w_head_reg),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_count     (w_count),
        .o_ent_valid (w_ent_valid),
        .o_ent_reg   (w_ent_reg)
    );

    // Marks q_ready usable from the first edge after reset release.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) r_live <= 1'b0;
        else             r_live <= 1'b1;
    end

    // Issue select: W wins, otherwise the FIFO head, otherwise idle.
    always_comb begin
        w_sel_en   = 1'b0;
        w_sel_reg  = r_wr_reg;
        w_sel_data = r_wr_data;
        if (w_issue_w) begin
            w_sel_en   = 1'b1;
            w_sel_reg  = bus.w_reg;
            w_sel_data = bus.w_data;
        end else if (w_pop) begin
            w_sel_en   = 1'b1;
            w_sel_reg  = w_head_reg;
            w_sel_data = w_head_data;
        end
    end

    // Output stage feeding the regfile; reg/data hold when idle.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_sel_en;
            r_wr_reg  <= w_sel_reg;
            r_wr_data <= w_sel_data;
        end
    end

    // Pending bitmap: every live FIFO slot plus the output stage when it writes.
    always_comb begin
        w_pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) w_pending_mask = w_pending_mask | reg_bit(32'(w_ent_reg[i]));
        end
        if (r_wr_en) w_pending_mask = w_pending_mask | reg_bit(32'(r_wr_reg));
    end

    assign w_waw_hit = w_issue_w && ((w_pending_mask & reg_bit(32'(bus.w_reg))) != '0);

    // Sticky write-after-write flag; only reset clears it.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset)    r_err_waw <= 1'b0;
        else if (w_waw_hit) r_err_waw <= 1'b1;
    end

    assign bus.q_ready      = w_q_ready;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_reg       = r_wr_reg;
    assign bus.wr_data      = r_wr_data;
    assign bus.pending_mask = w_pending_mask;
    assign bus.err_waw      = r_err_waw;

`ifdef REGFILE_WB_BYPASS_EN
    // Forward the write in flight to readers that sample the regfile this cycle.
    assign byp_hit_a  = r_wr_en && (r_wr_reg == byp_reg_a) && (byp_reg_a != ZERO_REG);
    assign byp_hit_b  = r_wr_en && (r_wr_reg == byp_reg_b) && (byp_reg_b != ZERO_REG);
    assign byp_data_a = byp_hit_a ? r_wr_data : '0;
    assign byp_data_b = byp_hit_b ? r_wr_data : '0;
`endif

endmodule
